// File: rtl/can_tx_sched_if.sv
// Handshake/bus bundle between the host, the CAN transmit scheduler and can_tx.
// Ports: mailbox load strobe/payload, per-mailbox abort, bus idle, launch/frame
// to can_tx, completion events from can_tx, per-mailbox status pulses.
interface can_tx_sched_if #(
  parameter int N_MBOX = 4
);
  localparam int SW = (N_MBOX > 1) ? $clog2(N_MBOX) : 1;

  // host -> scheduler
  logic              i_Load;
  logic [SW-1:0]     i_Load_Sel;
  logic [10:0]       i_Load_Id;
  logic [3:0]        i_Load_Dlc;
  logic [63:0]       i_Load_Data;
  logic [N_MBOX-1:0] i_Abort;
  logic              i_Bus_Idle;
  // scheduler <-> can_tx
  logic              o_Tx_Start;
  logic [10:0]       o_Tx_Id;
  logic [3:0]        o_Tx_Dlc;
  logic [63:0]       o_Tx_Data;
  logic              i_Tx_Done;
  logic              i_Tx_Arb_Lost;
  logic              i_Tx_Error;
  // scheduler -> host status
  logic [N_MBOX-1:0] o_Pending;
  logic [N_MBOX-1:0] o_Done;
  logic [N_MBOX-1:0] o_Fail;
  logic              o_Load_Err;

  // master: host side plus can_tx model; slave: the scheduler itself
  modport master (
    output i_Load, i_Load_Sel, i_Load_Id, i_Load_Dlc, i_Load_Data, i_Abort, i_Bus_Idle,
    output i_Tx_Done, i_Tx_Arb_Lost, i_Tx_Error,
    input  o_Tx_Start, o_Tx_Id, o_Tx_Dlc, o_Tx_Data,
    input  o_Pending, o_Done, o_Fail, o_Load_Err
  );

  modport slave (
    input  i_Load, i_Load_Sel, i_Load_Id, i_Load_Dlc, i_Load_Data, i_Abort, i_Bus_Idle,
    input  i_Tx_Done, i_Tx_Arb_Lost, i_Tx_Error,
    output o_Tx_Start, o_Tx_Id, o_Tx_Dlc, o_Tx_Data,
    output o_Pending, o_Done, o_Fail, o_Load_Err
  );
endinterface

// File: rtl/can_tx_sched.sv
// CAN transmit scheduler: N_MBOX mailboxes, lowest-Id-first launch on can_tx, retry on arb loss/error.
// Latency: load -> o_Tx_Start in 3 cycles; completion pulse -> o_Done/o_Fail next cycle, next launch >= 3 cycles.
// Backpressure: one frame in flight; loads to the in-flight mailbox are rejected (o_Load_Err), launch gated by i_Bus_Idle.
// Ports: i_Clock, i_Rst_n (async active-low) and the can_tx_sched_if slave bundle.
module can_tx_sched #(
  parameter int N_MBOX    = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  can_tx_sched_if.slave bus
);
  localparam int SW = (N_MBOX > 1) ? $clog2(N_MBOX) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, START, WAIT} state_t;

  state_t            state_q, state_d;
  logic [10:0]       id_q    [N_MBOX];
  logic [10:0]       id_d    [N_MBOX];
  logic [3:0]        dlc_q   [N_MBOX];
  logic [3:0]        dlc_d   [N_MBOX];
  logic [63:0]       data_q  [N_MBOX];
  logic [63:0]       data_d  [N_MBOX];
  logic [3:0]        retry_q [N_MBOX];
  logic [3:0]        retry_d [N_MBOX];
  logic [N_MBOX-1:0] pend_q, pend_d;
  logic [SW-1:0]     idx_q, idx_d;
  logic              abort_q, abort_d;
  logic [10:0]       tx_id_q, tx_id_d;
  logic [3:0]        tx_dlc_q, tx_dlc_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic [N_MBOX-1:0] done_q, done_d;
  logic [N_MBOX-1:0] fail_q, fail_d;
  logic              load_err_q, load_err_d;

  // Lowest Id wins; strict '<' keeps the lowest index on ties.
  logic          best_vld;
  logic [SW-1:0] best_idx;
  logic [10:0]   best_id;

  always_comb begin
    best_vld = 1'b0;
    best_idx = '0;
    best_id  = '1;
    for (int i = 0; i < N_MBOX; i++) begin
      if (pend_q[i] && (!best_vld || id_q[i] < best_id)) begin
        best_vld = 1'b1;
        best_idx = SW'(i);
        best_id  = id_q[i];
      end
    end
  end

  // The mailbox chosen in SELECT is already treated as in flight for aborts,
  // so an abort landing in that cycle is not lost between SELECT and START.
  logic          busy;
  logic          flight_vld;
  logic [SW-1:0] flight_idx;
  logic          abort_hit;
  logic          abort_now;
  logic [3:0]    retry_inc;
  logic [3:0]    load_dlc;

  always_comb begin
    busy       = (state_q == START) || (state_q == WAIT);
    flight_vld = busy || ((state_q == SELECT) && best_vld);
    flight_idx = (state_q == SELECT) ? best_idx : idx_q;
    abort_hit  = flight_vld && bus.i_Abort[flight_idx];
    abort_now  = abort_q || bus.i_Abort[idx_q];
    retry_inc  = retry_q[idx_q] + 4'd1;
    load_dlc   = (bus.i_Load_Dlc > 4'd8) ? 4'd8 : bus.i_Load_Dlc;
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    retry_d    = retry_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    abort_d    = abort_q;
    tx_id_d    = tx_id_q;
    tx_dlc_d   = tx_dlc_q;
    tx_data_d  = tx_data_q;
    done_d     = '0;
    fail_d     = '0;
    load_err_d = 1'b0;

    // Aborts of idle mailboxes act immediately; the in-flight one is deferred to WAIT exit.
    for (int i = 0; i < N_MBOX; i++) begin
      if (bus.i_Abort[i] && !(flight_vld && flight_idx == SW'(i))) begin
        pend_d[i] = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if ((|pend_q) && bus.i_Bus_Idle) state_d = SELECT;
      end
      SELECT: begin
        if (best_vld) begin
          idx_d     = best_idx;
          tx_id_d   = id_q[best_idx];
          tx_dlc_d  = dlc_q[best_idx];
          tx_data_d = data_q[best_idx];
          abort_d   = abort_hit && !(bus.i_Load && bus.i_Load_Sel == best_idx);
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        abort_d = abort_q || abort_hit;
        state_d = WAIT;
      end
      WAIT: begin
        abort_d = abort_q || abort_hit;
        if (bus.i_Tx_Done) begin
          pend_d[idx_q]  = 1'b0;
          done_d[idx_q]  = 1'b1;
          retry_d[idx_q] = 4'd0;
          state_d        = IDLE;
        end else if (bus.i_Tx_Error) begin
          if (abort_now) begin
            pend_d[idx_q] = 1'b0;
          end else if (retry_inc == 4'(MAX_RETRY)) begin
            pend_d[idx_q]  = 1'b0;
            fail_d[idx_q]  = 1'b1;
            retry_d[idx_q] = 4'd0;
          end else begin
            retry_d[idx_q] = retry_inc;
          end
          state_d = IDLE;
        end else if (bus.i_Tx_Arb_Lost) begin
          if (abort_now) pend_d[idx_q] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated last so a load overrides an abort to the same mailbox.
    if (bus.i_Load) begin
      if (busy && bus.i_Load_Sel == idx_q) begin
        load_err_d = 1'b1;
      end else begin
        id_d[bus.i_Load_Sel]    = bus.i_Load_Id;
        dlc_d[bus.i_Load_Sel]   = load_dlc;
        data_d[bus.i_Load_Sel]  = bus.i_Load_Data;
        pend_d[bus.i_Load_Sel]  = 1'b1;
        retry_d[bus.i_Load_Sel] = 4'd0;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < N_MBOX; i++) begin
        id_q[i]    <= '0;
        dlc_q[i]   <= '0;
        data_q[i]  <= '0;
        retry_q[i] <= '0;
      end
      pend_q     <= '0;
      idx_q      <= '0;
      abort_q    <= 1'b0;
      tx_id_q    <= '0;
      tx_dlc_q   <= '0;
      tx_data_q  <= '0;
      done_q     <= '0;
      fail_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      retry_q    <= retry_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      abort_q    <= abort_d;
      tx_id_q    <= tx_id_d;
      tx_dlc_q   <= tx_dlc_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.o_Tx_Start = (state_q == START);
  assign bus.o_Tx_Id    = tx_id_q;
  assign bus.o_Tx_Dlc   = tx_dlc_q;
  assign bus.o_Tx_Data  = tx_data_q;
  assign bus.o_Pending  = pend_q;
  assign bus.o_Done     = done_q;
  assign bus.o_Fail     = fail_q;
  assign bus.o_Load_Err = load_err_q;
endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched: reset, single frame, priority, arb loss, error retries,
// abort/load while in flight, reset mid-frame and bus-idle gating.
module tb_can_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   n;

  always #5 clk = ~clk;

  can_tx_sched_if #(.N_MBOX(4)) bus ();

  can_tx_sched #(.N_MBOX(4), .MAX_RETRY(3)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load(input int sel, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    bus.i_Load      = 1'b1;
    bus.i_Load_Sel  = 2'(sel);
    bus.i_Load_Id   = id;
    bus.i_Load_Dlc  = dlc;
    bus.i_Load_Data = data;
    tick();
    bus.i_Load      = 1'b0;
  endtask

  // Waits (bounded) for o_Tx_Start and checks the launched identifier.
  task automatic wait_launch(input string tag, input logic [10:0] exp_id);
    int k = 0;
    while (bus.o_Tx_Start !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_start"}, 64'(bus.o_Tx_Start), 64'd1);
    chk({tag, "_id"}, 64'(bus.o_Tx_Id), 64'(exp_id));
  endtask

  // From the START cycle: one WAIT cycle, then a one-cycle completion event (0 done, 1 arb, 2 error).
  task automatic complete(input int ev);
    tick();
    bus.i_Tx_Done     = (ev == 0);
    bus.i_Tx_Arb_Lost = (ev == 1);
    bus.i_Tx_Error    = (ev == 2);
    tick();
    bus.i_Tx_Done     = 1'b0;
    bus.i_Tx_Arb_Lost = 1'b0;
    bus.i_Tx_Error    = 1'b0;
  endtask

  task automatic count_starts(input int cycles, output int starts);
    starts = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (bus.o_Tx_Start === 1'b1) starts++;
    end
  endtask

  initial begin
    bus.i_Load = 1'b0; bus.i_Load_Sel = '0; bus.i_Load_Id = '0; bus.i_Load_Dlc = '0;
    bus.i_Load_Data = '0; bus.i_Abort = '0; bus.i_Bus_Idle = 1'b1;
    bus.i_Tx_Done = 1'b0; bus.i_Tx_Arb_Lost = 1'b0; bus.i_Tx_Error = 1'b0;

    // Reset state
    #2;
    chk("rst_start", 64'(bus.o_Tx_Start), 64'd0);
    chk("rst_id", 64'(bus.o_Tx_Id), 64'd0);
    chk("rst_pending", 64'(bus.o_Pending), 64'd0);
    chk("rst_done_fail", 64'({bus.o_Done, bus.o_Fail, bus.o_Load_Err}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single frame with exact latency
    load(0, 11'h123, 4'd2, 64'hABCD_0000_0000_0000);
    chk("sf_pending", 64'(bus.o_Pending), 64'b0001);
    tick();
    chk("sf_no_start_c2", 64'(bus.o_Tx_Start), 64'd0);
    tick();
    chk("sf_start_c3", 64'(bus.o_Tx_Start), 64'd1);
    chk("sf_id", 64'(bus.o_Tx_Id), 64'h123);
    chk("sf_dlc", 64'(bus.o_Tx_Dlc), 64'd2);
    chk("sf_data", bus.o_Tx_Data, 64'hABCD_0000_0000_0000);
    complete(0);
    chk("sf_done", 64'(bus.o_Done), 64'b0001);
    chk("sf_pending_clr", 64'(bus.o_Pending), 64'b0000);
    tick();
    chk("sf_done_pulse", 64'(bus.o_Done), 64'b0000);

    // Priority, with bus-idle gating holding off the launch until all are loaded
    bus.i_Bus_Idle = 1'b0;
    load(0, 11'h200, 4'd1, 64'h00);
    load(3, 11'h050, 4'd3, 64'h33);
    load(1, 11'h050, 4'd1, 64'h11);
    count_starts(5, n);
    chk("gate_no_start", 64'(n), 64'd0);
    chk("gate_pending", 64'(bus.o_Pending), 64'b1011);
    bus.i_Bus_Idle = 1'b1;
    tick(); tick();
    chk("pri1_start", 64'(bus.o_Tx_Start), 64'd1);
    chk("pri1_data", bus.o_Tx_Data, 64'h11);
    complete(0);
    chk("pri1_done", 64'(bus.o_Done), 64'b0010);
    chk("pri1_pending", 64'(bus.o_Pending), 64'b1001);
    tick(); tick();
    chk("pri2_start_c3", 64'(bus.o_Tx_Start), 64'd1);
    chk("pri2_data", bus.o_Tx_Data, 64'h33);
    complete(0);
    chk("pri2_done", 64'(bus.o_Done), 64'b1000);
    wait_launch("pri3", 11'h200);
    complete(0);
    chk("pri3_done", 64'(bus.o_Done), 64'b0001);
    chk("pri3_pending", 64'(bus.o_Pending), 64'b0000);

    // Arbitration loss: no retry consumed, so two later errors must not fail the frame
    load(2, 11'h7FF, 4'hC, 64'h7);
    wait_launch("arb0", 11'h7FF);
    chk("arb_dlc_clamp", 64'(bus.o_Tx_Dlc), 64'd8);
    for (int r = 0; r < 3; r++) begin
      complete(1);
      chk("arb_no_fail", 64'(bus.o_Fail), 64'd0);
      chk("arb_pending", 64'(bus.o_Pending), 64'b0100);
      tick(); tick();
      chk("arb_relaunch", 64'(bus.o_Tx_Start), 64'd1);
    end
    for (int r = 0; r < 2; r++) begin
      complete(2);
      chk("arb_err_no_fail", 64'(bus.o_Fail), 64'd0);
      wait_launch("arb_err_relaunch", 11'h7FF);
    end
    complete(0);
    chk("arb_done", 64'(bus.o_Done), 64'b0100);
    chk("arb_fail", 64'(bus.o_Fail), 64'd0);

    // Error retries: third error fails the frame
    load(1, 11'h100, 4'd1, 64'h5);
    for (int r = 0; r < 2; r++) begin
      wait_launch("err_launch", 11'h100);
      complete(2);
      chk("err_no_fail_yet", 64'(bus.o_Fail), 64'd0);
    end
    wait_launch("err_launch3", 11'h100);
    complete(2);
    chk("err_fail", 64'(bus.o_Fail), 64'b0010);
    chk("err_pending", 64'(bus.o_Pending), 64'b0000);
    count_starts(6, n);
    chk("err_no_4th_start", 64'(n), 64'd0);

    // Abort and load while in flight
    load(0, 11'h010, 4'd1, 64'h9);
    wait_launch("ab", 11'h010);
    tick();
    bus.i_Abort = 4'b0001;
    tick();
    bus.i_Abort = 4'b0000;
    chk("ab_deferred", 64'(bus.o_Pending), 64'b0001);
    load(0, 11'h3AA, 4'd1, 64'h1);
    chk("ab_load_err", 64'(bus.o_Load_Err), 64'd1);
    chk("ab_id_held", 64'(bus.o_Tx_Id), 64'h010);
    bus.i_Tx_Arb_Lost = 1'b1;
    tick();
    bus.i_Tx_Arb_Lost = 1'b0;
    chk("ab_load_err_pulse", 64'(bus.o_Load_Err), 64'd0);
    chk("ab_pending_clr", 64'(bus.o_Pending), 64'b0000);
    chk("ab_no_done_fail", 64'({bus.o_Done, bus.o_Fail}), 64'd0);
    count_starts(6, n);
    chk("ab_no_relaunch", 64'(n), 64'd0);

    // Reset mid-WAIT with three pending
    bus.i_Bus_Idle = 1'b0;
    load(0, 11'h020, 4'd1, 64'h1);
    load(1, 11'h030, 4'd1, 64'h2);
    load(2, 11'h040, 4'd1, 64'h3);
    bus.i_Bus_Idle = 1'b1;
    wait_launch("rs", 11'h020);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_start", 64'(bus.o_Tx_Start), 64'd0);
    chk("rs_frame", 64'({bus.o_Tx_Id, bus.o_Tx_Dlc}), 64'd0);
    chk("rs_data", bus.o_Tx_Data, 64'd0);
    chk("rs_status", 64'({bus.o_Pending, bus.o_Done, bus.o_Fail, bus.o_Load_Err}), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.i_Tx_Done = 1'b1;
    tick();
    bus.i_Tx_Done = 1'b0;
    chk("rs_done_ignored", 64'(bus.o_Done), 64'd0);
    count_starts(8, n);
    chk("rs_no_launch", 64'(n), 64'd0);
    load(3, 11'h001, 4'd0, 64'h0);
    tick(); tick();
    chk("rs_new_launch", 64'(bus.o_Tx_Start), 64'd1);
    chk("rs_new_id", 64'(bus.o_Tx_Id), 64'h001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
